// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command initiator: op codes, FSM states, div-by-zero result.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Divide-by-zero result is all ones at whatever width the datapath uses.
    localparam logic DIV0_FILL = 1'b1;
    localparam logic DIV0_OVF  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with zero flag, times the ALU settle window.
// Latency: load/decrement visible one cycle after the edge that applies them.
// Backpressure: none; decrements are ignored once the count is zero.
module lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_initiator.sv
// Sequences commands into an external combinational ALU, captures result/overflow, keeps an accumulator.
// Latency: response valid ALU_LAT cycles after command acceptance (divide by zero: 1 cycle).
// Backpressure: one command in flight; cmd_ready low until the response is consumed, response held indefinitely.
module alu_cmd_initiator
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] acc_value,
    output logic             ovf_sticky,
    output logic             busy
);

    localparam int             CW     = $clog2(ALU_LAT) + 1;
    localparam logic [CW-1:0]  LAT_M1 = CW'(ALU_LAT - 1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] alu_ina_q,   alu_ina_d;
    logic [WIDTH-1:0] alu_inb_q,   alu_inb_d;
    logic [1:0]       alu_sel_q,   alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_ovf_q,   rsp_ovf_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic             sticky_q,    sticky_d;
    logic             busy_q,      busy_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic div_zero;

    lat_counter #(
        .W (CW)
    ) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_M1),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign div_zero = (cmd_op == OP_DIV) && (cmd_b == '0);

    // Next-state and datapath updates for the IDLE -> WAIT -> RESP command sequence.
    always_comb begin
        state_d     = state_q;
        alu_ina_d   = alu_ina_q;
        alu_inb_d   = alu_inb_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_valid_d = rsp_valid_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rsp_valid_d = 1'b0;
                if (cmd_valid) begin
                    // Operand A reads the accumulator as registered, before any same-cycle clear.
                    alu_ina_d = cmd_acc ? acc_q : cmd_a;
                    alu_inb_d = cmd_b;
                    alu_sel_d = cmd_op;
                    cnt_load  = 1'b1;
                    if (div_zero) begin
                        // Result fixed here; rsp_valid follows from RESP on the next edge,
                        // so a divide by zero looks like a single-cycle operation.
                        rsp_data_d = {WIDTH{DIV0_FILL}};
                        rsp_ovf_d  = DIV0_OVF;
                        acc_d      = {WIDTH{DIV0_FILL}};
                        sticky_d   = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    rsp_data_d  = alu_out;
                    rsp_ovf_d   = alu_ovf;
                    rsp_valid_d = 1'b1;
                    acc_d       = alu_out;
                    sticky_d    = sticky_q | alu_ovf;
                    state_d     = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Clear beats any capture for the accumulator and sticky flag; rsp_* are unaffected.
        if (acc_clr) begin
            acc_d    = '0;
            sticky_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, ALU input and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_ina_q   <= '0;
            alu_inb_q   <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_ina_q   <= alu_ina_d;
            alu_inb_q   <= alu_inb_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_valid_q <= rsp_valid_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign alu_ina    = alu_ina_q;
    assign alu_inb    = alu_inb_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign acc_value  = acc_q;
    assign ovf_sticky = sticky_q;
    assign busy       = busy_q;

endmodule
